// File: rtl/ddr_addr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_addr_pkg
// Shared definitions for the DDR address generators: default address widths,
// the cluster-stride width, the address-walker state encoding and a helper
// that turns the "cluster count minus one" config field into a stride.
// ---------------------------------------------------------------------------
package ddr_addr_pkg;

   localparam int ROW_W_DEF = 16;
   localparam int COL_W_DEF = 14;

   // Stride spans 1..8, so it needs four bits.
   localparam int STRIDE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_VALID = 2'd1,
      ST_ADV   = 2'd2
   } walk_state_t;

   function automatic logic [STRIDE_W-1:0] stride_of(input logic [2:0] cluster_num);
      return {1'b0, cluster_num} + STRIDE_W'(1);
   endfunction

endpackage

// File: rtl/addr_ch_walk_if.sv
// ---------------------------------------------------------------------------
// addr_ch_walk_if
// Row/column address beat channel (valid/ready handshake).
//   addr_valid_o  : beat valid, driven by the walker
//   addr_ready_i  : downstream accepts the beat
//   addr_row_o    : current row address
//   addr_col_o    : current column address
// Modports: master = address walker, slave = downstream consumer.
// ---------------------------------------------------------------------------
interface addr_ch_walk_if
   import ddr_addr_pkg::*;
#(
   parameter int ROW_W = ROW_W_DEF,
   parameter int COL_W = COL_W_DEF
);
   logic             addr_valid_o;
   logic             addr_ready_i;
   logic [ROW_W-1:0] addr_row_o;
   logic [COL_W-1:0] addr_col_o;

   modport master (
      output addr_valid_o,
      output addr_row_o,
      output addr_col_o,
      input  addr_ready_i
   );

   modport slave (
      input  addr_valid_o,
      input  addr_row_o,
      input  addr_col_o,
      output addr_ready_i
   );
endinterface

// File: rtl/pos_step.sv
// ---------------------------------------------------------------------------
// pos_step
// Combinational single-position raster move inside a row/column block.
//   row, col         : current position
//   row_max, col_max : largest valid row / column index
//   row_major        : 1 = column advances first, 0 = row advances first
//   next_row/next_col: position one raster step later
// The fastest index wraps to zero at its maximum and carries into the other
// index. The carry itself is unsigned and wraps at the port width; callers
// stop before stepping past the last position.
// ---------------------------------------------------------------------------
module pos_step #(
   parameter int ROW_W = 16,
   parameter int COL_W = 14
) (
   input  logic [ROW_W-1:0] row,
   input  logic [COL_W-1:0] col,
   input  logic [ROW_W-1:0] row_max,
   input  logic [COL_W-1:0] col_max,
   input  logic             row_major,
   output logic [ROW_W-1:0] next_row,
   output logic [COL_W-1:0] next_col
);
   always_comb begin
      next_row = row;
      next_col = col;
      if (row_major) begin
         if (col == col_max) begin
            next_col = '0;
            next_row = row + ROW_W'(1);
         end else begin
            next_col = col + COL_W'(1);
         end
      end else begin
         if (row == row_max) begin
            next_row = '0;
            next_col = col + COL_W'(1);
         end else begin
            next_row = row + ROW_W'(1);
         end
      end
   end
endmodule

// File: rtl/addr_ch_walk.sv
// ---------------------------------------------------------------------------
// addr_ch_walk
// Walks a row/column block from a start position, issuing one address beat
// every "stride" raster positions until the last position is passed.
//   clk, rst_n             : clock, synchronous active-low reset
//   cfg_broadcast_i        : broadcast mode, blocks start
//   start_i                : one-cycle walk request (honoured in IDLE only)
//   cfg_row_column_i       : 1 = column advances first, 0 = row first
//   cfg_ch_cluster_num_i   : stride minus one
//   cfg_row_num_1st_i      : row maximum
//   cfg_column_num_1st_i   : column maximum
//   cfg_start_pos_row_i/col: start position
//   bus (master)           : address beat channel
//   busy_o                 : walk in progress (VALID or ADV)
//   done_o                 : one-cycle end-of-walk pulse
//   err_o                  : one-cycle pulse, start position out of range
//   beat_cnt_o             : beats accepted in the current/last walk
// ---------------------------------------------------------------------------
module addr_ch_walk
   import ddr_addr_pkg::*;
#(
   parameter int ROW_W = ROW_W_DEF,
   parameter int COL_W = COL_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_broadcast_i,
   input  logic                 start_i,
   input  logic                 cfg_row_column_i,
   input  logic [2:0]           cfg_ch_cluster_num_i,
   input  logic [ROW_W-1:0]     cfg_row_num_1st_i,
   input  logic [COL_W-1:0]     cfg_column_num_1st_i,
   input  logic [ROW_W-1:0]     cfg_start_pos_row_i,
   input  logic [COL_W-1:0]     cfg_start_pos_col_i,
   addr_ch_walk_if.master       bus,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [31:0]          beat_cnt_o
);
   walk_state_t         state_reg;
   logic [ROW_W-1:0]    row_reg;
   logic [COL_W-1:0]    col_reg;
   logic [ROW_W-1:0]    row_max_reg;
   logic [COL_W-1:0]    col_max_reg;
   logic                row_major_reg;
   logic [STRIDE_W-1:0] stride_reg;
   logic [STRIDE_W-1:0] remain_reg;
   logic                valid_reg;
   logic                busy_reg;
   logic                done_reg;
   logic                err_reg;
   logic [31:0]         beat_cnt_reg;

   logic [ROW_W-1:0]    step_row;
   logic [COL_W-1:0]    step_col;
   logic                at_end;

   pos_step #(
      .ROW_W (ROW_W),
      .COL_W (COL_W)
   ) u_pos_step (
      .row       (row_reg),
      .col       (col_reg),
      .row_max   (row_max_reg),
      .col_max   (col_max_reg),
      .row_major (row_major_reg),
      .next_row  (step_row),
      .next_col  (step_col)
   );

   assign at_end = (row_reg == row_max_reg) && (col_reg == col_max_reg);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         row_reg       <= '0;
         col_reg       <= '0;
         row_max_reg   <= '0;
         col_max_reg   <= '0;
         row_major_reg <= 1'b0;
         stride_reg    <= '0;
         remain_reg    <= '0;
         valid_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         beat_cnt_reg  <= '0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start_i && !cfg_broadcast_i) begin
                  row_reg       <= cfg_start_pos_row_i;
                  col_reg       <= cfg_start_pos_col_i;
                  row_max_reg   <= cfg_row_num_1st_i;
                  col_max_reg   <= cfg_column_num_1st_i;
                  row_major_reg <= cfg_row_column_i;
                  stride_reg    <= stride_of(cfg_ch_cluster_num_i);
                  beat_cnt_reg  <= '0;
                  // Range check uses the same values being latched.
                  if ((cfg_start_pos_row_i > cfg_row_num_1st_i) ||
                      (cfg_start_pos_col_i > cfg_column_num_1st_i)) begin
                     done_reg <= 1'b1;
                     err_reg  <= 1'b1;
                  end else begin
                     state_reg <= ST_VALID;
                     valid_reg <= 1'b1;
                     busy_reg  <= 1'b1;
                  end
               end
            end
            ST_VALID: begin
               if (bus.addr_ready_i) begin
                  beat_cnt_reg <= beat_cnt_reg + 32'd1;
                  remain_reg   <= stride_reg;
                  valid_reg    <= 1'b0;
                  state_reg    <= ST_ADV;
               end
            end
            ST_ADV: begin
               if (at_end) begin
                  // Nothing left to walk: finish even with moves pending.
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end else begin
                  row_reg    <= step_row;
                  col_reg    <= step_col;
                  remain_reg <= remain_reg - STRIDE_W'(1);
                  if (remain_reg == STRIDE_W'(1)) begin
                     state_reg <= ST_VALID;
                     valid_reg <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.addr_valid_o = valid_reg;
   assign bus.addr_row_o   = row_reg;
   assign bus.addr_col_o   = col_reg;
   assign busy_o           = busy_reg;
   assign done_o           = done_reg;
   assign err_o            = err_reg;
   assign beat_cnt_o       = beat_cnt_reg;
endmodule

// File: tb/tb_addr_ch_walk.sv
// ---------------------------------------------------------------------------
// tb_addr_ch_walk
// Directed walks through addr_ch_walk with hand-computed beat lists.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_addr_ch_walk;
   localparam int ROW_W = 16;
   localparam int COL_W = 14;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_broadcast_i = 1'b0;
   logic             start_i = 1'b0;
   logic             cfg_row_column_i = 1'b0;
   logic [2:0]       cfg_ch_cluster_num_i = '0;
   logic [ROW_W-1:0] cfg_row_num_1st_i = '0;
   logic [COL_W-1:0] cfg_column_num_1st_i = '0;
   logic [ROW_W-1:0] cfg_start_pos_row_i = '0;
   logic [COL_W-1:0] cfg_start_pos_col_i = '0;
   logic             busy_o;
   logic             done_o;
   logic             err_o;
   logic [31:0]      beat_cnt_o;

   addr_ch_walk_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

   addr_ch_walk #(.ROW_W(ROW_W), .COL_W(COL_W)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .cfg_broadcast_i      (cfg_broadcast_i),
      .start_i              (start_i),
      .cfg_row_column_i     (cfg_row_column_i),
      .cfg_ch_cluster_num_i (cfg_ch_cluster_num_i),
      .cfg_row_num_1st_i    (cfg_row_num_1st_i),
      .cfg_column_num_1st_i (cfg_column_num_1st_i),
      .cfg_start_pos_row_i  (cfg_start_pos_row_i),
      .cfg_start_pos_col_i  (cfg_start_pos_col_i),
      .bus                  (bus),
      .busy_o               (busy_o),
      .done_o               (done_o),
      .err_o                (err_o),
      .beat_cnt_o           (beat_cnt_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   int          got_row [32];
   int          got_col [32];
   int          got_cyc [32];
   int          got_n;
   logic        done_seen;
   logic        done_err;
   int          done_cyc;
   logic [31:0] done_cnt;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_beat(input int i, input int r, input int c);
      chk($sformatf("beat%0d_row", i), longint'(got_row[i]), longint'(r));
      chk($sformatf("beat%0d_col", i), longint'(got_col[i]), longint'(c));
   endtask

   // Caller sits on a falling edge; start_i is high across one rising edge.
   task automatic start_walk(input int rmax, input int cmax, input logic row_major,
                             input int cl, input int sr, input int sc);
      cfg_row_num_1st_i    = ROW_W'(rmax);
      cfg_column_num_1st_i = COL_W'(cmax);
      cfg_row_column_i     = row_major;
      cfg_ch_cluster_num_i = 3'(cl);
      cfg_start_pos_row_i  = ROW_W'(sr);
      cfg_start_pos_col_i  = COL_W'(sc);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Records accepted beats until done_o, bounded by a cycle budget.
   task automatic collect(input int budget);
      got_n     = 0;
      done_seen = 1'b0;
      done_err  = 1'b0;
      done_cyc  = 0;
      done_cnt  = '0;
      for (int k = 0; k < budget; k++) begin
         if (bus.addr_valid_o && bus.addr_ready_i) begin
            if (got_n < 32) begin
               got_row[got_n] = int'(bus.addr_row_o);
               got_col[got_n] = int'(bus.addr_col_o);
               got_cyc[got_n] = cyc;
            end
            $display("beat %0d row=%0d col=%0d cyc=%0d", got_n, bus.addr_row_o, bus.addr_col_o, cyc);
            got_n++;
         end
         if (done_o) begin
            done_seen = 1'b1;
            done_err  = err_o;
            done_cyc  = cyc;
            done_cnt  = beat_cnt_o;
            $display("done cyc=%0d beats=%0d", cyc, beat_cnt_o);
            break;
         end
         @(negedge clk);
      end
      chk("walk_done_seen", longint'(done_seen), 1);
   endtask

   task automatic chk_done_cleared(input string tag);
      @(negedge clk);
      chk({tag, "_done_pulse"}, longint'(done_o), 0);
      chk({tag, "_busy_after"}, longint'(busy_o), 0);
   endtask

   initial begin
      bus.addr_ready_i = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", longint'(bus.addr_valid_o), 0);
      chk("rst_busy",  longint'(busy_o), 0);
      chk("rst_done",  longint'(done_o), 0);
      chk("rst_err",   longint'(err_o), 0);
      chk("rst_row",   longint'(bus.addr_row_o), 0);
      chk("rst_col",   longint'(bus.addr_col_o), 0);
      chk("rst_cnt",   longint'(beat_cnt_o), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Row-major, 2x3 block, stride 1
      start_walk(1, 2, 1'b1, 0, 0, 0);
      chk("t1_busy", longint'(busy_o), 1);
      collect(200);
      chk("t1_nbeats", longint'(got_n), 6);
      chk_beat(0, 0, 0); chk_beat(1, 0, 1); chk_beat(2, 0, 2);
      chk_beat(3, 1, 0); chk_beat(4, 1, 1); chk_beat(5, 1, 2);
      chk("t1_gap", longint'(got_cyc[1] - got_cyc[0]), 2);
      chk("t1_cnt", longint'(done_cnt), 6);
      chk("t1_err", longint'(done_err), 0);
      chk_done_cleared("t1");

      // Row-major, stride 3 from (0,1)
      start_walk(1, 2, 1'b1, 2, 0, 1);
      collect(200);
      chk("t2_nbeats", longint'(got_n), 2);
      chk_beat(0, 0, 1); chk_beat(1, 1, 1);
      chk("t2_gap", longint'(got_cyc[1] - got_cyc[0]), 4);
      chk("t2_done_lat", longint'(done_cyc - got_cyc[1]), 3);
      chk("t2_cnt", longint'(done_cnt), 2);
      chk_done_cleared("t2");

      // Column-major, 3x2 block, stride 1
      start_walk(2, 1, 1'b0, 0, 0, 0);
      collect(200);
      chk("t3_nbeats", longint'(got_n), 6);
      chk_beat(0, 0, 0); chk_beat(1, 1, 0); chk_beat(2, 2, 0);
      chk_beat(3, 0, 1); chk_beat(4, 1, 1); chk_beat(5, 2, 1);
      chk("t3_cnt", longint'(done_cnt), 6);
      chk_done_cleared("t3");

      // Backpressure: ready low for 5 cycles in VALID
      bus.addr_ready_i = 1'b0;
      start_walk(3, 3, 1'b1, 0, 2, 3);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t4_hold%0d_valid", k), longint'(bus.addr_valid_o), 1);
         chk($sformatf("t4_hold%0d_row", k),   longint'(bus.addr_row_o), 2);
         chk($sformatf("t4_hold%0d_col", k),   longint'(bus.addr_col_o), 3);
         chk($sformatf("t4_hold%0d_cnt", k),   longint'(beat_cnt_o), 0);
         @(negedge clk);
      end
      bus.addr_ready_i = 1'b1;
      collect(200);
      chk("t4_nbeats", longint'(got_n), 5);
      chk_beat(0, 2, 3); chk_beat(1, 3, 0); chk_beat(4, 3, 3);
      chk("t4_cnt", longint'(done_cnt), 5);
      chk_done_cleared("t4");

      // Start position out of range
      start_walk(2, 2, 1'b1, 0, 3, 0);
      chk("t5_done",  longint'(done_o), 1);
      chk("t5_err",   longint'(err_o), 1);
      chk("t5_valid", longint'(bus.addr_valid_o), 0);
      chk("t5_busy",  longint'(busy_o), 0);
      @(negedge clk);
      chk("t5_done_next",  longint'(done_o), 0);
      chk("t5_err_next",   longint'(err_o), 0);
      chk("t5_valid_next", longint'(bus.addr_valid_o), 0);

      // Reset during ADV
      start_walk(1, 2, 1'b1, 2, 0, 0);
      @(negedge clk);
      chk("t6_adv_valid", longint'(bus.addr_valid_o), 0);
      chk("t6_adv_busy",  longint'(busy_o), 1);
      chk("t6_adv_cnt",   longint'(beat_cnt_o), 1);
      @(negedge clk);
      chk("t6_adv_col",   longint'(bus.addr_col_o), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_valid", longint'(bus.addr_valid_o), 0);
      chk("t6_rst_busy",  longint'(busy_o), 0);
      chk("t6_rst_done",  longint'(done_o), 0);
      chk("t6_rst_err",   longint'(err_o), 0);
      chk("t6_rst_row",   longint'(bus.addr_row_o), 0);
      chk("t6_rst_col",   longint'(bus.addr_col_o), 0);
      chk("t6_rst_cnt",   longint'(beat_cnt_o), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Broadcast blocks start
      cfg_broadcast_i = 1'b1;
      start_walk(1, 2, 1'b1, 0, 0, 0);
      chk("t7_busy",  longint'(busy_o), 0);
      chk("t7_valid", longint'(bus.addr_valid_o), 0);
      chk("t7_done",  longint'(done_o), 0);
      @(negedge clk);
      chk("t7_busy_later", longint'(busy_o), 0);
      cfg_broadcast_i = 1'b0;

      // Start while busy, with cfg changed mid-walk
      bus.addr_ready_i = 1'b0;
      start_walk(1, 2, 1'b1, 0, 0, 0);
      cfg_column_num_1st_i = COL_W'(0);
      cfg_row_column_i     = 1'b0;
      cfg_ch_cluster_num_i = 3'd3;
      cfg_start_pos_row_i  = ROW_W'(1);
      cfg_start_pos_col_i  = COL_W'(1);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      bus.addr_ready_i = 1'b1;
      chk("t8_row", longint'(bus.addr_row_o), 0);
      chk("t8_col", longint'(bus.addr_col_o), 0);
      collect(200);
      chk("t8_nbeats", longint'(got_n), 6);
      chk_beat(0, 0, 0); chk_beat(2, 0, 2); chk_beat(3, 1, 0); chk_beat(5, 1, 2);
      chk("t8_cnt", longint'(done_cnt), 6);
      chk_done_cleared("t8");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
